// File: rtl/bus_handshake_pkg.sv
// Shared definitions for the toggle request/acknowledge bus crossing (rx and tx sides).
// Holds the receiver state encoding and the default crossed-bus width.
package bus_handshake_pkg;

    localparam int BHRX_WIDTH_DEF = 32;

    typedef enum logic {
        BHRX_IDLE  = 1'b0,
        BHRX_VALID = 1'b1
    } bhrx_state_e;

    // A request is outstanding whenever the synchronized toggle differs from the last one taken.
    function automatic logic bhrx_new_req(input logic req_sync, input logic req_seen);
        return req_sync ^ req_seen;
    endfunction

endpackage

// File: rtl/bus_handshake_rx_if.sv
// Crossed bus plus destination-side valid/ready handshake of the toggle receiver.
// master = source model / local consumer side, slave = bus_handshake_rx.
interface bus_handshake_rx_if
    import bus_handshake_pkg::*;
#(
    parameter int WIDTH = BHRX_WIDTH_DEF
);

    logic             src_req_tgl;
    logic [WIDTH-1:0] src_data;
    logic             dest_valid;
    logic [WIDTH-1:0] dest_data;
    logic             dest_ready;
    logic             dest_pulse;
    logic             dest_ack_tgl;
    logic             protocol_err;

    modport master (
        output src_req_tgl,
        output src_data,
        output dest_ready,
        input  dest_valid,
        input  dest_data,
        input  dest_pulse,
        input  dest_ack_tgl,
        input  protocol_err
    );

    modport slave (
        input  src_req_tgl,
        input  src_data,
        input  dest_ready,
        output dest_valid,
        output dest_data,
        output dest_pulse,
        output dest_ack_tgl,
        output protocol_err
    );

endinterface

// File: rtl/bus_handshake_rx_levelsync.sv
// Two-flop level synchronizer for a slow toggle signal into the destination clock.
// Latency 2 edges; no backpressure. Flop names are stable for CDC constraints.
module bus_handshake_rx_levelsync #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_lvl,
    output logic o_lvl
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= RESET_VALUE;
            r_sync <= RESET_VALUE;
        end else begin
            r_meta <= i_lvl;
            r_sync <= r_meta;
        end
    end

    assign o_lvl = r_sync;

endmodule

// File: rtl/bus_handshake_rx.sv
// Toggle-request receiver: captures the quasi-static source bus and offers it valid/ready.
// Latency 3 edges req->valid; holds the word while dest_ready=0, acks with a toggle on accept.
module bus_handshake_rx
    import bus_handshake_pkg::*;
#(
    parameter int               WIDTH      = BHRX_WIDTH_DEF,
    parameter logic [WIDTH-1:0] DATA_RESET = '0
) (
    input  logic                clk_dest,
    input  logic                rst_dest_n,
    bus_handshake_rx_if.slave   bus
);

    bhrx_state_e      r_state;
    bhrx_state_e      w_state_nxt;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] w_data_nxt;
    logic             r_req_seen;
    logic             w_req_seen_nxt;
    logic             r_pulse;
    logic             w_pulse_nxt;
    logic             r_ack;
    logic             w_ack_nxt;
    logic             r_err;
    logic             w_err_nxt;
    logic             w_req_sync;
    logic             w_new_req;

    bus_handshake_rx_levelsync #(
        .RESET_VALUE (1'b0)
    ) u_req_sync (
        .clk   (clk_dest),
        .rst_n (rst_dest_n),
        .i_lvl (bus.src_req_tgl),
        .o_lvl (w_req_sync)
    );

    assign w_new_req = bhrx_new_req(w_req_sync, r_req_seen);

    always_comb begin
        w_state_nxt    = r_state;
        w_data_nxt     = r_data;
        w_req_seen_nxt = r_req_seen;
        w_pulse_nxt    = 1'b0;
        w_ack_nxt      = r_ack;
        w_err_nxt      = r_err;
        case (r_state)
            BHRX_IDLE: begin
                if (w_new_req) begin
                    w_data_nxt     = bus.src_data;
                    w_req_seen_nxt = w_req_sync;
                    w_pulse_nxt    = 1'b1;
                    w_state_nxt    = BHRX_VALID;
                end
            end
            BHRX_VALID: begin
                // A toggle here means the source did not wait for our ack; keep the pending word.
                if (w_new_req) begin
                    w_err_nxt = 1'b1;
                end
                if (bus.dest_ready) begin
                    w_ack_nxt   = ~r_ack;
                    w_state_nxt = BHRX_IDLE;
                end
            end
            default: begin
                w_state_nxt = BHRX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_dest or negedge rst_dest_n) begin
        if (!rst_dest_n) begin
            r_state    <= BHRX_IDLE;
            r_req_seen <= 1'b0;
            r_pulse    <= 1'b0;
            r_ack      <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_req_seen <= w_req_seen_nxt;
            r_pulse    <= w_pulse_nxt;
            r_ack      <= w_ack_nxt;
            r_err      <= w_err_nxt;
        end
    end

    // Capture flops sample src_data unsynchronized (stable by protocol): multicycle/false-path target.
    always_ff @(posedge clk_dest or negedge rst_dest_n) begin
        if (!rst_dest_n) begin
            r_data <= DATA_RESET;
        end else begin
            r_data <= w_data_nxt;
        end
    end

    assign bus.dest_valid   = (r_state == BHRX_VALID);
    assign bus.dest_data    = r_data;
    assign bus.dest_pulse   = r_pulse;
    assign bus.dest_ack_tgl = r_ack;
    assign bus.protocol_err = r_err;

endmodule
